// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the ID-stage controller.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, source-register usage, illegal flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int ENABLE_JUMP = 1
) (
  input  logic [6:0]   opcode,
  input  logic [4:0]   rd,
  output ctrl_bundle_t bundle,
  output logic         uses_rs1,
  output logic         uses_rs2,
  output logic         illegal
);

  always_comb begin
    bundle       = BUBBLE;
    bundle.valid = 1'b1;
    bundle.rd    = rd;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    illegal      = 1'b0;
    case (opcode)
      OP_R: begin
        bundle.reg_write = 1'b1;
        bundle.alu_op    = ALU_OP_RTYPE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = ALU_OP_ITYPE;
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        bundle.alu_src    = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.alu_op     = ALU_OP_ADD;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        bundle.alu_src   = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.alu_op    = ALU_OP_ADD;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        bundle.branch = 1'b1;
        bundle.alu_op = ALU_OP_BRANCH;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        if (ENABLE_JUMP != 0) begin
          bundle.jump      = 1'b1;
          bundle.reg_write = 1'b1;
          bundle.alu_op    = ALU_OP_ADD;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (ENABLE_JUMP != 0) begin
          bundle.jump      = 1'b1;
          bundle.alu_src   = 1'b1;
          bundle.reg_write = 1'b1;
          bundle.alu_op    = ALU_OP_ADD;
          uses_rs1 = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // An undecodable opcode must never look like a real instruction downstream.
    if (illegal) begin
      bundle   = BUBBLE;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode/hazard controller: stall/flush strobes, ID/EX control register, EX clock-gate.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int ENABLE_JUMP = 1,
  parameter int IDLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        illegal_op,
  output logic        ex_valid,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_mem_read,
  output logic        ex_mem_to_reg,
  output logic        ex_mem_write,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic [1:0]  ex_alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_gate_en
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
  localparam logic [3:0] IDLE_MAX     = 4'(IDLE_CYCLES);

  state_t       state, state_nxt;
  logic [1:0]   flush_cnt, flush_cnt_nxt;
  logic [3:0]   idle_cnt, idle_cnt_nxt;
  ctrl_bundle_t ex_q, ex_nxt, dec_bundle;
  logic         illegal_nxt, gate_nxt;
  logic         uses_rs1, uses_rs2, dec_illegal, hazard;
  logic         pc_write_c, if_id_write_c, if_id_flush_c;
  logic [4:0]   rs1, rs2;
  logic         unused_instr_bits;

  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  ctrl_decode #(.ENABLE_JUMP(ENABLE_JUMP)) u_decode (
    .opcode   (id_instr[6:0]),
    .rd       (id_instr[11:7]),
    .bundle   (dec_bundle),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (dec_illegal)
  );

  // x0 destinations are never real producers, so they cannot create a hazard.
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                  ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    ex_nxt        = BUBBLE;
    illegal_nxt   = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          if_id_flush_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_RELOAD;
          end
        end else if (hazard) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
        end else if (id_valid) begin
          if (dec_illegal) illegal_nxt = 1'b1;
          else             ex_nxt      = dec_bundle;
        end
      end
      ST_FLUSH: begin
        if_id_flush_c = 1'b1;
        if (ex_redirect) begin
          flush_cnt_nxt = FLUSH_RELOAD;
        end else if (flush_cnt <= 2'd1) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = 2'd0;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end
      default: begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (ex_nxt.valid)            idle_cnt_nxt = 4'd0;
    else if (idle_cnt < IDLE_MAX) idle_cnt_nxt = idle_cnt + 4'd1;
    gate_nxt = ex_nxt.valid | (idle_cnt_nxt < IDLE_MAX);
  end

  // Fetch keeps running and nothing is flushed while the pipeline is held in reset.
  assign pc_write    = pc_write_c | rst;
  assign if_id_write = if_id_write_c | rst;
  assign if_id_flush = if_id_flush_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_cnt  <= 2'd0;
      idle_cnt   <= 4'd0;
      ex_q       <= BUBBLE;
      illegal_op <= 1'b0;
      ex_gate_en <= 1'b1;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
      ex_q       <= ex_nxt;
      illegal_op <= illegal_nxt;
      ex_gate_en <= gate_nxt;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rd         = ex_q.rd;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Registered decode-and-hazard controller for the 5-stage RV32 pipeline. Sits between the IF/ID and ID/EX pipeline registers. Each cycle it:
- decodes the ID-stage instruction into the existing control bundle;
- detects load-use hazards and branch/jump redirects;
- drives stall/flush strobes to IF/ID and the PC;
- registers the bundle into the ID/EX control register.

An idle counter deasserts an EX-stage clock-gate enable after a run of bubbles, for power saving.

## Interface
Parameters:
- FLUSH_DEPTH, 1: number of consecutive ID/EX bubbles inserted per redirect (1 = resolve in EX, 2 = resolve in MEM); legal 1..3.
- ENABLE_JUMP, 1: decode JAL (1101111) and JALR (1100111); 0 = treat them as illegal.
- IDLE_CYCLES, 4: consecutive bubbles in ID/EX before ex_gate_en drops; legal 1..15.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  IF/ID instruction: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- ex_redirect  in  1  branch taken or jump resolved in EX/MEM this cycle.
- pc_write  out  1  PC update enable (combinational).
- if_id_write  out  1  IF/ID load enable (combinational).
- if_id_flush  out  1  IF/ID clear to bubble (combinational).
- illegal_op  out  1  one-cycle registered pulse; an undecodable valid opcode entered ID/EX as a bubble.
- ex_valid  out  1  registered.
- ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered.
- ex_alu_op  out  2  registered.
- ex_rd  out  5  registered.
- ex_gate_en  out  1  registered EX clock-gate enable.

## Operation
- Decode, applied when id_valid=1:
  - R-type 0110011: reg_write, alu_op=10.
  - I-ALU 0010011: alu_src, reg_write, alu_op=11.
  - LW 0000011: alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - SW 0100011: alu_src, mem_write, alu_op=00.
  - BEQ 1100011: branch, alu_op=01.
  - JAL: jump, reg_write, alu_op=00.
  - JALR: jump, alu_src, reg_write, alu_op=00.
  - Anything else: illegal.
- Bubble: all ex_* control outputs 0, ex_rd=0, ex_valid=0.
- Register use:
  - rs1 is used by R, I-ALU, LW, SW, BEQ, JALR.
  - rs2 is used by R, SW, BEQ.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- FSM states:
  - RUN.
  - FLUSH: counter flush_cnt holds the remaining bubbles.
- RUN behaviour:
  - ex_redirect=1: if_id_flush=1, pc_write=1, if_id_write=1, ID/EX←bubble. If FLUSH_DEPTH>1, go to FLUSH with flush_cnt=FLUSH_DEPTH-1; otherwise stay in RUN.
  - Else load-use hazard: pc_write=0, if_id_write=0, ID/EX←bubble.
  - Else: ID/EX←decoded bundle. An illegal opcode instead loads a bubble and pulses illegal_op.
- FLUSH behaviour:
  - if_id_flush=1, ID/EX←bubble, flush_cnt decrements.
  - Return to RUN when flush_cnt reaches 1 at the edge.
  - A new ex_redirect in FLUSH reloads flush_cnt=FLUSH_DEPTH-1.
- Precedence: redirect > load-use stall > normal decode. The stalled instruction is wrong-path and is discarded.
- Idle counter:
  - Increments (saturating at IDLE_CYCLES) on every edge that loads a bubble.
  - Clears on every edge that loads a valid bundle.
  - ex_gate_en = (idle_cnt < IDLE_CYCLES). Its next-state value is forced to 1 whenever a valid bundle is loaded, so EX is ungated the same cycle the instruction arrives.

## Timing
- ID/EX outputs: 1-cycle latency from id_instr.
- pc_write, if_id_write and if_id_flush are combinational from current inputs and state; no registered delay.
- Load-use stall lasts exactly 1 cycle. Next cycle ex_mem_read=0, so the hazard clears.
- Redirect at cycle N: bubbles appear in ID/EX for cycles N+1 .. N+FLUSH_DEPTH.
- Reset (async, any state, including mid-FLUSH):
  - state=RUN, flush_cnt=0, idle_cnt=0.
  - All ex_* outputs are 0, i.e. a bubble.
  - illegal_op=0, ex_gate_en=1.
  - Combinational outputs during reset: pc_write=1, if_id_write=1, if_id_flush=0.
- ex_rd=0 never triggers a hazard (x0 writes are ignored).

## Structure
- Shared package pipe_ctrl_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR);
  - ALU_OP_* 2-bit codes;
  - a ctrl_bundle_t struct and its BUBBLE constant.
- One combinational sub-module, ctrl_decode: opcode → ctrl_bundle_t, uses_rs1, uses_rs2, illegal.
- The top level holds the FSM, counters and ID/EX register.

## Test plan
- Reset mid-FLUSH (FLUSH_DEPTH=3, rst pulsed asynchronously between edges) → all ex_* outputs 0, ex_gate_en=1, state RUN. First valid ADDI after release appears at ex_* one cycle later.
- LW x5 followed by ADD x6,x5,x1 → one cycle with pc_write=0, if_id_write=0 and a bubble in ID/EX; then ADD issues with alu_op=10. Repeat with rd=x0 → no stall.
- ex_redirect while a load-use hazard is present (FLUSH_DEPTH=2) → if_id_flush=1, pc_write=1, then exactly 2 bubbles. A second redirect during FLUSH restarts the count.
- Opcode 0110111 with id_valid=1 → illegal_op pulses once and a bubble enters ID/EX. With ENABLE_JUMP=0, JAL also flags illegal.
- id_valid=0 for 6 cycles (IDLE_CYCLES=4) → ex_gate_en drops after the 4th bubble edge and returns to 1 on the edge loading the next SW, where ex_mem_write=1.
- Back-to-back BEQ, JALR, SW with no hazards → ex_* outputs match the decode rules on consecutive cycles, with no stalls.
